imuldiv_div_requester: RTL and testbench

IMULDIV_DIV_REQUESTER -- requirements
Module: imuldiv_div_requester

---
 rtl/imuldiv_div_requester_pkg.sv | 37 +++
 rtl/imuldiv_div_requester.sv | 124 ++++++++++++
 tb/tb_imuldiv_div_requester.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imuldiv_div_requester_pkg.sv
// Shared definitions for the divide requester: op and FSM encodings, widths
// and small decode helpers.
package imuldiv_div_requester_pkg;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_WAIT = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  // Even op codes (DIV, REM) are the signed flavours.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

  // Divide-by-zero answer: all ones for a quotient, the dividend for a remainder.
  function automatic logic [DATA_W-1:0] divzero_result(input logic [1:0] op,
                                                       input logic [DATA_W-1:0] a);
    return op_is_rem(op) ? a : {DATA_W{1'b1}};
  endfunction

endpackage

// File: rtl/imuldiv_div_requester.sv
// Single-outstanding command sequencer in front of an iterative divider.
// Optional IMULDIV_DIVZERO_BYPASS_EN answers b==0 commands without the divider.
module imuldiv_div_requester
  import imuldiv_div_requester_pkg::*;
(
  input  logic              clk,
  input  logic              reset,

  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [TAG_W-1:0]  cmd_tag,
  input  logic              cmd_val,
  output logic              cmd_rdy,

  output logic              divreq_msg_fn,
  output logic [DATA_W-1:0] divreq_msg_a,
  output logic [DATA_W-1:0] divreq_msg_b,
  output logic              divreq_val,
  input  logic              divreq_rdy,

  input  logic [2*DATA_W-1:0] divresp_msg_result,
  input  logic              divresp_val,
  output logic              divresp_rdy,

  output logic [DATA_W-1:0] resp_result,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              resp_val,
  input  logic              resp_rdy
);

  state_e            state_q;
  state_e            state_d;

  logic [1:0]        op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [TAG_W-1:0]  tag_q;
  logic [DATA_W-1:0] result_q;

  logic              cmd_fire;
  logic              divreq_fire;
  logic              divresp_fire;
  logic              resp_fire;
  logic              bypass;

`ifdef IMULDIV_DIVZERO_BYPASS_EN
  assign bypass = (cmd_b == '0);
`else
  assign bypass = 1'b0;
`endif

  assign cmd_fire     = cmd_val     & cmd_rdy;
  assign divreq_fire  = divreq_val  & divreq_rdy;
  assign divresp_fire = divresp_val & divresp_rdy;
  assign resp_fire    = resp_val    & resp_rdy;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmd_fire)     state_d = bypass ? ST_RESP : ST_SEND;
      ST_SEND: if (divreq_fire)  state_d = ST_WAIT;
      ST_WAIT: if (divresp_fire) state_d = ST_RESP;
      ST_RESP: if (resp_fire)    state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs depend on state only, so no rdy input reaches a val output.
  always_comb begin
    cmd_rdy     = 1'b0;
    divreq_val  = 1'b0;
    divresp_rdy = 1'b0;
    resp_val    = 1'b0;
    case (state_q)
      ST_IDLE: cmd_rdy     = 1'b1;
      ST_SEND: divreq_val  = 1'b1;
      ST_WAIT: divresp_rdy = 1'b1;
      ST_RESP: resp_val    = 1'b1;
      default: ;
    endcase
  end

  // Command fields are captured once at accept and stay put for the transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      tag_q <= '0;
    end else if (cmd_fire) begin
      op_q  <= cmd_op;
      a_q   <= cmd_a;
      b_q   <= cmd_b;
      tag_q <= cmd_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
    end else if (cmd_fire && bypass) begin
      result_q <= divzero_result(cmd_op, cmd_a);
    end else if (divresp_fire) begin
      result_q <= op_is_rem(op_q) ? divresp_msg_result[2*DATA_W-1:DATA_W]
                                  : divresp_msg_result[DATA_W-1:0];
    end
  end

  assign divreq_msg_fn = op_is_signed(op_q);
  assign divreq_msg_a  = a_q;
  assign divreq_msg_b  = b_q;

  assign resp_result   = result_q;
  assign resp_tag      = tag_q;

endmodule

// File: tb/tb_imuldiv_div_requester.sv
// Scoreboard bench for imuldiv_div_requester with a behavioural divider model.
module tb_imuldiv_div_requester;

  logic        clk;
  logic        reset;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [3:0]  cmd_tag;
  logic        cmd_val;
  logic        cmd_rdy;
  logic        divreq_msg_fn;
  logic [31:0] divreq_msg_a;
  logic [31:0] divreq_msg_b;
  logic        divreq_val;
  logic        divreq_rdy;
  logic [63:0] divresp_msg_result;
  logic        divresp_val;
  logic        divresp_rdy;
  logic [31:0] resp_result;
  logic [3:0]  resp_tag;
  logic        resp_val;
  logic        resp_rdy;

  imuldiv_div_requester dut (
    .clk(clk), .reset(reset),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .cmd_val(cmd_val), .cmd_rdy(cmd_rdy),
    .divreq_msg_fn(divreq_msg_fn), .divreq_msg_a(divreq_msg_a),
    .divreq_msg_b(divreq_msg_b), .divreq_val(divreq_val), .divreq_rdy(divreq_rdy),
    .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val),
    .divresp_rdy(divresp_rdy),
    .resp_result(resp_result), .resp_tag(resp_tag), .resp_val(resp_val),
    .resp_rdy(resp_rdy)
  );

  typedef struct {
    logic [31:0] result;
    logic [3:0]  tag;
    int          acc_cyc;
    int          lat;
  } exp_t;

  typedef struct {
    logic        fn;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  exp_t exp_q[$];
  req_t req_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit fast = 0;
  bit hold = 0;
  bit abandon = 0;
  int resp_stall = 0;
  int divreq_stall = 0;

`ifdef IMULDIV_DIVZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural divider: RISC-V style results for zero divisor and signed overflow.
  function automatic logic [63:0] div_model(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'hFFFFFFFF;
      r = a;
    end else if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      q = 32'h80000000;
      r = 32'd0;
    end else if (sgn) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic        sgn;
    logic [63:0] m;
    sgn = (op == 2'b00) || (op == 2'b10);
    m   = div_model(sgn, a, b);
    return (op == 2'b10 || op == 2'b11) ? m[63:32] : m[31:0];
  endfunction

  // Divider model process
  initial begin : divider
    bit          pend;
    int          delay;
    logic [63:0] res;
    bit          stalled;
    logic [64:0] prev_req;
    pend = 0; delay = 0; res = '0; stalled = 0; prev_req = '0;
    divreq_rdy = 1'b0;
    divresp_val = 1'b0;
    divresp_msg_result = '0;
    forever begin
      @(negedge clk);
      if (abandon) begin
        divresp_val = 1'b1;
        divresp_msg_result = 64'hDEADBEEF_CAFEF00D;
        pend = 0;
        abandon = 0;
      end else begin
        divresp_val = pend && (delay == 0) && !hold;
        divresp_msg_result = res;
      end
      if (divreq_stall > 0) divreq_rdy = 1'b0;
      else if (fast)        divreq_rdy = 1'b1;
      else                  divreq_rdy = ($urandom_range(0, 2) != 0);
      #1;
      if (!reset) begin
        if (divresp_val && divresp_rdy) pend = 0;
        if (divreq_val) begin
          check("divresp_rdy_in_send", {63'd0, divresp_rdy}, 64'd0);
          check("cmd_rdy_in_send", {63'd0, cmd_rdy}, 64'd0);
          if (stalled)
            check("divreq_hold", {31'd0, divreq_msg_fn, divreq_msg_a, divreq_msg_b}, {31'd0, prev_req});
          if (divreq_rdy) begin
            stalled = 0;
            check("divreq_expected", {63'd0, req_q.size() != 0}, 64'd1);
            if (req_q.size() != 0) begin
              req_t r;
              r = req_q.pop_front();
              check("divreq_fn", {63'd0, divreq_msg_fn}, {63'd0, r.fn});
              check("divreq_ab", {divreq_msg_a, divreq_msg_b}, {r.a, r.b});
            end
            res = div_model(divreq_msg_fn, divreq_msg_a, divreq_msg_b);
            pend = 1;
            delay = fast ? 0 : $urandom_range(0, 4);
          end else begin
            stalled = 1;
            prev_req = {divreq_msg_fn, divreq_msg_a, divreq_msg_b};
            if (divreq_stall > 0) divreq_stall--;
          end
        end else begin
          if (stalled) check("divreq_val_dropped", {63'd0, divreq_val}, 64'd1);
          stalled = 0;
          if (pend && delay > 0 && !hold) delay--;
        end
      end else begin
        stalled = 0;
      end
    end
  end

  // Response monitor / scoreboard
  initial begin : monitor
    bit          prev_val;
    logic [35:0] prev_resp;
    prev_val = 0; prev_resp = '0;
    resp_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_stall > 0) resp_rdy = 1'b0;
      else if (fast)      resp_rdy = 1'b1;
      else                resp_rdy = ($urandom_range(0, 3) != 0);
      #1;
      if (reset) begin
        prev_val = 0;
      end else if (resp_val) begin
        check("cmd_rdy_in_resp", {63'd0, cmd_rdy}, 64'd0);
        if (prev_val) begin
          check("resp_hold", {28'd0, resp_result, resp_tag}, {28'd0, prev_resp});
        end else if (exp_q.size() != 0 && exp_q[0].lat >= 0) begin
          check("resp_latency", 64'(cyc - exp_q[0].acc_cyc), 64'(exp_q[0].lat));
        end
        if (resp_rdy) begin
          check("resp_expected", {63'd0, exp_q.size() != 0}, 64'd1);
          if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("resp_result", {32'd0, resp_result}, {32'd0, e.result});
            check("resp_tag", {60'd0, resp_tag}, {60'd0, e.tag});
          end
          prev_val = 0;
        end else begin
          prev_val = 1;
          prev_resp = {resp_result, resp_tag};
          if (resp_stall > 0) resp_stall--;
        end
      end else begin
        if (prev_val) check("resp_val_dropped", {63'd0, resp_val}, 64'd1);
        prev_val = 0;
      end
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag, input bit use_exp, input logic [31:0] exp_res,
                          input int lat);
    int   n;
    exp_t e;
    req_t r;
    bit   byp;
    @(negedge clk);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_val = 1'b1;
    #1;
    n = 0;
    while (!cmd_rdy && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!cmd_rdy) begin
      check("cmd_accept_timeout", 64'd0, 64'd1);
    end else begin
      byp = BYPASS && (b == 32'd0);
      e.result  = use_exp ? exp_res : ref_result(op, a, b);
      e.tag     = tag;
      e.acc_cyc = cyc;
      e.lat     = (lat >= 0 && byp) ? 1 : lat;
      exp_q.push_back(e);
      if (!byp) begin
        r.fn = ~op[0];
        r.a  = a;
        r.b  = b;
        req_q.push_back(r);
      end
    end
    @(negedge clk);
    cmd_val = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !cmd_rdy) && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain_timeout", {63'd0, exp_q.size() == 0 && cmd_rdy}, 64'd1);
  endtask

  initial begin : main
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          n;
    reset = 1'b1;
    cmd_val = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_cmd_rdy", {63'd0, cmd_rdy}, 64'd1);
    check("rst_divreq_val", {63'd0, divreq_val}, 64'd0);
    check("rst_divresp_rdy", {63'd0, divresp_rdy}, 64'd0);
    check("rst_resp_val", {63'd0, resp_val}, 64'd0);
    check("rst_resp_result", {32'd0, resp_result}, 64'd0);
    check("rst_resp_tag", {60'd0, resp_tag}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    fast = 1;
    send_cmd(2'b00, 32'hFFFFFFF9, 32'd2, 4'd3, 1, 32'hFFFFFFFD, 3);
    wait_idle();
    send_cmd(2'b11, 32'd100, 32'd7, 4'd5, 1, 32'd2, 3);
    wait_idle();
    resp_stall = 5;
    send_cmd(2'b01, 32'd20, 32'd3, 4'd9, 1, 32'd6, 3);
    wait_idle();
    divreq_stall = 3;
    send_cmd(2'b01, 32'd1000, 32'd10, 4'd1, 1, 32'd100, 6);
    wait_idle();
    send_cmd(2'b10, 32'd55, 32'd0, 4'd2, 1, 32'd55, 3);
    wait_idle();
    send_cmd(2'b00, 32'd55, 32'd0, 4'd4, 1, 32'hFFFFFFFF, 3);
    wait_idle();
    send_cmd(2'b00, 32'h80000000, 32'hFFFFFFFF, 4'd6, 1, 32'h80000000, 3);
    wait_idle();

    fast = 0;
    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h80000000;
      send_cmd(op, a, b, 4'($urandom_range(0, 15)), 0, 32'd0, -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();

    // Abandon a transaction in WAIT, then deliver the stale response.
    hold = 1;
    send_cmd(2'b01, 32'd9, 32'd3, 4'd7, 1, 32'd3, -1);
    n = 0;
    while (!divresp_rdy && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("reach_wait", {63'd0, divresp_rdy}, 64'd1);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    req_q.delete();
    hold = 0;
    abandon = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("late_resp_val", {63'd0, resp_val}, 64'd0);
      check("late_cmd_rdy", {63'd0, cmd_rdy}, 64'd1);
      check("late_divresp_rdy", {63'd0, divresp_rdy}, 64'd0);
      check("late_resp_data", {28'd0, resp_result, resp_tag}, 64'd0);
    end

    fast = 1;
    send_cmd(2'b01, 32'd50, 32'd5, 4'd8, 1, 32'd10, 3);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
